// File: rtl/instr_encoder_if.sv
// Request/output bundle between the program loader and instr_encoder.
// The master builds requests and consumes words; the slave is the encoder.
interface instr_encoder_if #(
  parameter int DEPTH = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    kind;
  logic [2:0]    funct3;
  logic          funct7b5;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [31:0]   imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_addr;
  logic [31:0]   out_word;
  logic [CW-1:0] count;
  logic          full;
  logic          err;

  modport master (
    output clear, in_valid, kind, funct3, funct7b5, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, out_addr, out_word, count, full, err
  );

  modport slave (
    input  clear, in_valid, kind, funct3, funct7b5, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, out_addr, out_word, count, full, err
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I word assembler: field requests -> encoded words at sequential addresses.
// 1-cycle latency, 1 word/cycle; requests stall while full, clearing, or the output is held.
module instr_encoder #(
  parameter int          DEPTH = 64,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input logic           clk,
  input logic           reset,
  instr_encoder_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    K_LOAD   = 3'd0,
    K_STORE  = 3'd1,
    K_RTYPE  = 3'd2,
    K_BRANCH = 3'd3,
    K_ITYPE  = 3'd4,
    K_JAL    = 3'd5,
    K_LUI    = 3'd6,
    K_NOP    = 3'd7
  } kind_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_addr_q,  out_addr_d;
  logic [31:0]   out_word_q,  out_word_d;
  logic [31:0]   addr_q,      addr_d;
  logic [CW-1:0] count_q,     count_d;
  logic          err_q,       err_d;

  logic               full;
  logic               in_ready;
  logic               accept;
  logic [31:0]        enc_word;
  logic               legal;
  logic signed [31:0] simm;
  logic               fits12;
  logic               fits_br;
  logic               fits_jal;
  logic               shamt_ok;
  logic               is_shift;

  assign full     = (count_q == CW'(DEPTH));
  // Gated by reset so every output reads 0 while reset is held.
  assign in_ready = reset && !full && !bus.clear && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign simm     = $signed(bus.imm);
  assign fits12   = (simm >= -32'sd2048) && (simm <= 32'sd2047);
  assign fits_br  = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !bus.imm[0];
  assign fits_jal = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !bus.imm[0];
  assign shamt_ok = (bus.imm[31:5] == 27'd0);
  assign is_shift = (bus.funct3 == 3'b101);

  always_comb begin
    enc_word = 32'h0000_0013;
    legal    = 1'b1;
    case (kind_e'(bus.kind))
      K_LOAD: begin
        enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OP_LOAD};
        legal    = fits12;
      end
      K_STORE: begin
        enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], OP_STORE};
        legal    = fits12;
      end
      K_RTYPE: begin
        enc_word = {1'b0, bus.funct7b5, 5'b00000, bus.rs2, bus.rs1, bus.funct3, bus.rd, OP_RTYPE};
      end
      K_ITYPE: begin
        if (is_shift) begin
          enc_word = {1'b0, bus.funct7b5, 5'b00000, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd,
                      OP_ITYPE};
          legal    = shamt_ok;
        end else begin
          enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OP_ITYPE};
          legal    = fits12;
        end
      end
      K_BRANCH: begin
        enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                    bus.imm[4:1], bus.imm[11], OP_BRANCH};
        legal    = fits_br;
      end
      K_JAL: begin
        enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, OP_JAL};
        legal    = fits_jal;
      end
      K_LUI: begin
        enc_word = {bus.imm[31:12], bus.rd, OP_LUI};
        legal    = (bus.imm[11:0] == 12'd0);
      end
      default: begin
        enc_word = 32'h0000_0013;
        legal    = 1'b1;
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q && !bus.out_ready;
    out_addr_d  = out_addr_q;
    out_word_d  = out_word_q;
    addr_d      = addr_q;
    count_d     = count_q;
    err_d       = err_q;
    if (bus.clear) begin
      out_valid_d = 1'b0;
      addr_d      = BASE;
      count_d     = '0;
      err_d       = 1'b0;
    end else if (accept) begin
      if (legal) begin
        out_valid_d = 1'b1;
        out_addr_d  = addr_q;
        out_word_d  = enc_word;
        addr_d      = addr_q + 32'd4;
        count_d     = count_q + 1'b1;
      end else begin
        // Illegal requests are swallowed; only the sticky flag records them.
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= 32'd0;
      out_word_q  <= 32'd0;
      addr_q      <= BASE;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_word_q  <= out_word_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_word  = out_word_q;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a scoreboard of expected {addr, word} pairs.
module tb_instr_encoder;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset;

  instr_encoder_if #(.DEPTH(DEPTH)) bus ();

  instr_encoder #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          acc_seen;
  logic [31:0] addr_m;
  logic [63:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge (handshakes, scoreboard), return 1ns after posedge.
  task automatic step();
    logic [63:0] e;
    @(negedge clk);
    acc_seen = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_word", bus.out_word, 32'hxxxx_xxxx);
      end else begin
        e = sb_q.pop_front();
        chk("sb_addr", bus.out_addr, e[63:32]);
        chk("sb_word", bus.out_word, e[31:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] k, input logic [2:0] f3, input logic f7,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im, input bit legal, input logic [31:0] exp_word);
    bus.kind = k; bus.funct3 = f3; bus.funct7b5 = f7;
    bus.rd = d; bus.rs1 = s1; bus.rs2 = s2; bus.imm = im;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc_seen) break;
    end
    chk("accept", {31'd0, acc_seen}, 32'd1);
    bus.in_valid = 1'b0;
    if (legal) begin
      sb_q.push_back({addr_m, exp_word});
      addr_m += 32'd4;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) step();
    chk("drain", sb_q.size(), 32'd0);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    addr_m = BASE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    reset = 1'b0;
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.kind = 3'd7; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
    bus.rd = 5'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.imm = 32'd0;
    addr_m = BASE;
    #3;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_full_err", {30'd0, bus.full, bus.err}, 32'd0);
    chk("rst_out_word", bus.out_word, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // LOAD with the output held, then 5 stalled cycles
    bus.out_ready = 1'b0;
    send(3'd0, 3'b010, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8, 1'b1, 32'h0081_2283);
    chk("load_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("load_word", bus.out_word, 32'h0081_2283);
    chk("load_addr", bus.out_addr, BASE);
    chk("load_count", 32'(bus.count), 32'd1);
    held = bus.out_word;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("hold_word", bus.out_word, held);
    end
    bus.out_ready = 1'b1;
    drain();
    do_clear();
    chk("clear_count", 32'(bus.count), 32'd0);

    // back-to-back RTYPE then BRANCH -4
    send(3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020_81B3);
    chk("add_word", bus.out_word, 32'h0020_81B3);
    send(3'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h4020_81B3);
    chk("sub_word", bus.out_word, 32'h4020_81B3);
    chk("sub_addr", bus.out_addr, BASE + 32'd4);
    send(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b1, 32'hFE20_8EE3);
    drain();
    do_clear();

    // JAL, LUI, then an illegal misaligned branch
    send(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 32'h0080_00EF);
    send(3'd6, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7);
    send(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'd0);
    chk("illegal_no_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("illegal_err", {31'd0, bus.err}, 32'd1);
    chk("illegal_count", 32'(bus.count), 32'd2);
    send(3'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 32'h0000_0013);
    chk("after_illegal_addr", bus.out_addr, BASE + 32'd8);
    chk("err_sticky", {31'd0, bus.err}, 32'd1);
    drain();
    do_clear();
    chk("clear_err", {31'd0, bus.err}, 32'd0);

    // ITYPE shift (srai x1,x2,3) and addi with negative immediate
    send(3'd4, 3'b101, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3, 1'b1, 32'h4031_5093);
    send(3'd4, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF1_0093);
    drain();
    do_clear();

    // fill to DEPTH; the fifth request must stall
    for (int i = 0; i < DEPTH; i++)
      send(3'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 32'h0000_0013);
    chk("full_flag", {31'd0, bus.full}, 32'd1);
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.kind = 3'd7;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fifth_stalls", {31'd0, acc_seen}, 32'd0);
    end
    bus.in_valid = 1'b0;
    chk("drained_no_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("full_still_count", 32'(bus.count), 32'd4);
    drain();
    do_clear();
    chk("clear_full", {31'd0, bus.full}, 32'd0);
    send(3'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 32'h0000_0013);
    chk("clear_base_addr", bus.out_addr, BASE);
    drain();

    // reset with a word pending drops it at once
    bus.out_ready = 1'b0;
    send(3'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 32'h0000_0013);
    chk("pending_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("reset_drops_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_count", 32'(bus.count), 32'd0);
    sb_q.delete();
    addr_m = BASE;
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(3'd6, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7);
    chk("post_reset_addr", bus.out_addr, BASE);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Assembles RV32I instruction words from field-level requests and emits them with sequential addresses to the instruction-memory loader.
- Serves as the encode side of the pipeline control decoder. It covers the same opcode subset: load, store, R-type, branch, I-type ALU, jal, lui and nop.
- Used by the program loader and by self-checking benches to build programs into instruction memory.

Parameters:
- DEPTH, 64: words per program image; the address counter saturates at this count.
- BASE, 32'h0000_0000: byte address of the first emitted word.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart: empties the image and returns the address to BASE.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted this cycle when in_valid=1.
- kind  in  3  0 LOAD, 1 STORE, 2 RTYPE, 3 BRANCH, 4 ITYPE, 5 JAL, 6 LUI, 7 NOP.
- funct3  in  3  funct3 field.
- funct7b5  in  1  instr[30] for RTYPE and for ITYPE shifts (funct3=101).
- rd, rs1, rs2  in  5 each  register indices.
- imm  in  32  signed byte immediate (for LUI, the full upper value).
- out_valid  out  1  encoded word pending.
- out_ready  in  1  loader consumes word.
- out_addr  out  32  byte address of the word.
- out_word  out  32  encoded instruction.
- count  out  $clog2(DEPTH)+1  legal words accepted since reset or clear.
- full  out  1  count==DEPTH.
- err  out  1  sticky illegal-request flag.

Behaviour:

Clock and reset:
- One clock; reset is asynchronous and active-low.
- While reset=0, all outputs are 0 and the internal address is BASE.

Input handshake:
- in_ready = !full && !clear && (!out_valid || out_ready).
- A request is accepted on a clk edge where in_valid && in_ready.

Encoding, with opcodes:
- LOAD 0000011: {imm[11:0], rs1, funct3, rd, op}.
- STORE 0100011: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
- RTYPE 0110011: {0, funct7b5, 00000, rs2, rs1, funct3, rd, op}.
- ITYPE 0010011: {imm[11:0], rs1, funct3, rd, op}. When funct3=101, bits [31:25] = {0, funct7b5, 00000} and bits [24:20] = imm[4:0].
- BRANCH 1100011: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
- JAL 1101111: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- LUI 0110111: {imm[31:12], rd, op}.
- NOP: 32'h0000_0013.
- Unused fields are ignored.

Legality checks (failure makes the request illegal):
- LOAD, STORE, ITYPE non-shift: imm in [-2048, 2047].
- ITYPE shift: imm in [0, 31].
- BRANCH: imm in [-4096, 4094] and imm[0]=0.
- JAL: imm in [-2^20, 2^20-2] and imm[0]=0.
- LUI: imm[11:0]=0.

Legal accept:
- The next cycle has out_valid=1, out_word = encoding, out_addr = current address.
- Address += 4 and count += 1, both registered at the accept edge.
- Latency is 1 cycle.

Illegal accept:
- The request is consumed.
- No output is produced; address and count are unchanged; err is set to 1.
- err holds until reset or clear.

Output register:
- out_valid, out_addr and out_word hold stable while out_valid && !out_ready.
- out_valid clears on the out_ready edge unless a new accept occurs in the same cycle. A back-to-back accept replaces the word, giving 1 word/cycle throughput.

full:
- Asserts the cycle after the DEPTH-th legal accept.
- A pending word still drains normally.
- Further requests stall (in_ready=0); there is no wrap.

clear:
- Synchronous.
- Next cycle: out_valid=0 (pending word discarded), address=BASE, count=0, err=0.
- Overrides any accept in the same cycle.

Reset mid-transfer:
- Drops the pending word immediately.
- Asynchronous deassertion is assumed synchronized upstream.

Test Plan:
- LOAD rd=5, rs1=2, funct3=010, imm=8 after reset -> next cycle out_valid=1, out_word=32'h0081_2283, out_addr=BASE, count=1.
- RTYPE rd=3, rs1=1, rs2=2, funct3=0 with funct7b5=0, then 1, out_ready=1 -> words 32'h0020_81B3 then 32'h4020_81B3 on consecutive cycles, addresses BASE and BASE+4.
- BRANCH rs1=1, rs2=2, funct3=0, imm=-4 -> 32'hFE20_8EE3.
- JAL rd=1, imm=8 -> 32'h0080_00EF.
- LUI rd=5, imm=32'h1234_5000 -> 32'h1234_52B7.
- BRANCH imm=3 -> in_ready=1 that cycle; no out_valid; err=1; count unchanged. The next legal request uses the unchanged address.
- Hold out_ready=0 with a word pending -> in_ready=0 and out_word stable over 5 cycles.
- With DEPTH=4, issue 5 NOPs -> four words of 32'h0000_0013 and full=1; the 5th stalls.
- Pulse clear -> count=0, out_addr of the next word = BASE, err=0.
- Assert reset while out_valid=1 -> out_valid=0 in the same cycle.
